// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported SRAM between the fetch port and the
//               load/store port. Data wins by default; a bounded starvation
//               counter forces a fetch grant after STARVE_MAX lost cycles.
//               Read responses are routed back to the issuing port one cycle
//               after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    // load/store port
    input  logic        i_d_req,
    input  logic [3:0]  i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    // memory macro
    output logic        o_mem_en,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    // pipeline stall
    output logic        o_cpu_wait
);

    localparam logic [3:0]  C_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [31:0] C_WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    logic [3:0] r_starve_cnt;
    owner_t     r_resp_owner;
    logic       r_resp_is_wr;

    logic       w_if_gnt;
    logic       w_d_gnt;
    logic       w_if_rvalid;
    logic       w_d_rvalid;

    // Arbitration: data first unless fetch has already lost STARVE_MAX times
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (i_d_req && (!i_if_req || (r_starve_cnt < C_STARVE_MAX))) begin
                w_d_gnt = 1'b1;
            end else if (i_if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    // Memory drive from whichever port holds the grant; idle bus is all zero
    always_comb begin
        o_mem_we    = 4'b0000;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        if (w_d_gnt) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr & C_WORD_MASK;
            o_mem_wdata = i_d_wdata;
        end else if (w_if_gnt) begin
            o_mem_addr  = i_if_addr & C_WORD_MASK;
        end
    end

    // Count consecutive cycles a waiting fetch loses to data, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_if_gnt || !i_if_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_d_gnt && (r_starve_cnt < C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Remember who owns the response arriving next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_owner <= OWN_NONE;
            r_resp_is_wr <= 1'b0;
        end else begin
            r_resp_owner <= w_if_gnt ? OWN_IF : (w_d_gnt ? OWN_D : OWN_NONE);
            r_resp_is_wr <= w_d_gnt && (i_d_we != 4'b0000);
        end
    end

    // Response routing; reset masks any response still in flight
    always_comb begin
        w_if_rvalid = !rst && (r_resp_owner == OWN_IF);
        w_d_rvalid  = !rst && (r_resp_owner == OWN_D);
        o_if_rdata  = w_if_rvalid ? i_mem_rdata : 32'h0;
        o_d_rdata   = (w_d_rvalid && !r_resp_is_wr) ? i_mem_rdata : 32'h0;
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_if_rvalid = w_if_rvalid;
    assign o_d_rvalid  = w_d_rvalid;
    assign o_mem_en    = w_if_gnt | w_d_gnt;
    assign o_cpu_wait  = !rst && ((i_if_req && !w_if_gnt) || (i_d_req && !w_d_gnt));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A reference model
//               predicts grants and memory drive each cycle; expected
//               responses are queued at grant time and popped one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int unsigned SM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        cpu_wait;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_cpu_wait  (cpu_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  own;   // 0 none, 1 fetch, 2 data
        logic        wr;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic        m_gi, m_gd;
    logic [3:0]  m_cnt = 4'd0;
    logic [31:0] nxt_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic step(input logic ifr, input logic [31:0] ifa,
                        input logic dr, input logic [3:0] dwe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic rs, input logic [31:0] nrd);
        resp_t       e;
        logic [31:0] ex_addr;
        logic        ex_ifv, ex_dv;
        @(negedge clk);
        rst       = rs;
        if_req    = ifr;
        if_addr   = ifa;
        d_req     = dr;
        d_we      = dwe;
        d_addr    = da;
        d_wdata   = dwd;
        mem_rdata = nxt_rdata;
        #1;
        if (rs) begin
            m_gi = 1'b0;
            m_gd = 1'b0;
        end else begin
            m_gd = dr && (!ifr || (m_cnt < 4'(SM)));
            m_gi = ifr && !m_gd;
        end
        ex_addr = m_gd ? {da[31:2], 2'b00} : (m_gi ? {ifa[31:2], 2'b00} : 32'h0);
        chk("if_gnt",    32'(if_gnt),   32'(m_gi));
        chk("d_gnt",     32'(d_gnt),    32'(m_gd));
        chk("mem_en",    32'(mem_en),   32'(m_gi | m_gd));
        chk("mem_we",    32'(mem_we),   m_gd ? 32'(dwe) : 32'h0);
        chk("mem_addr",  mem_addr,      ex_addr);
        chk("mem_wdata", mem_wdata,     m_gd ? dwd : 32'h0);
        chk("cpu_wait",  32'(cpu_wait), 32'(!rs && ((ifr && !m_gi) || (dr && !m_gd))));
        if (!rs) chk("starve_cnt", 32'(dut.r_starve_cnt), 32'(m_cnt));
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '{own: 2'd0, wr: 1'b0, data: 32'h0};
        ex_ifv = !rs && (e.own == 2'd1);
        ex_dv  = !rs && (e.own == 2'd2);
        chk("if_rvalid", 32'(if_rvalid), 32'(ex_ifv));
        chk("d_rvalid",  32'(d_rvalid),  32'(ex_dv));
        chk("if_rdata",  if_rdata, ex_ifv ? e.data : 32'h0);
        chk("d_rdata",   d_rdata,  (ex_dv && !e.wr) ? e.data : 32'h0);
        nxt_rdata = nrd;
        sb.push_back('{own: (m_gi ? 2'd1 : (m_gd ? 2'd2 : 2'd0)),
                       wr: (m_gd && (dwe != 4'b0000)), data: nrd});
        if (rs || m_gi || !ifr) m_cnt = 4'd0;
        else if (m_gd && (m_cnt < 4'(SM))) m_cnt = m_cnt + 4'd1;
    endtask

    logic [5:0]  gseq;
    logic        wait_all;
    logic        p_if, p_d;
    logic [31:0] r_ifa, r_da, r_dwd;
    logic [3:0]  r_dwe;
    int          lat, max_lat;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0;
        d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;

        // Reset held two cycles with both ports requesting
        step(1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 1, 32'hA5A5_0001);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        step(1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 1, 32'hA5A5_0002);
        step(1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 0, 32'h0000_1234);
        chk("post_rst_d_gnt", 32'(d_gnt), 32'h1);
        chk("post_rst_wait",  32'(cpu_wait), 32'h1);
        step(1, 32'h40, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0000_5678);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);

        // Fetch alone
        step(1, 32'h0000_0106, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0013_0513);
        chk("fetch_addr", mem_addr, 32'h0000_0104);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        chk("fetch_rdata", if_rdata, 32'h0013_0513);

        // Data write: ack carries zero data even though mem_rdata is nonzero
        step(0, 32'h0, 1, 4'b1100, 32'h200, 32'hBEEF_0000, 0, 32'hDEAD_DEAD);
        chk("wr_mem_we", 32'(mem_we), 32'hC);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        chk("wr_ack_rdata", d_rdata, 32'h0);

        // Starvation: fetch held, data re-requested for six cycles
        wait_all = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 32'h300, 1, 4'h0, 32'h400 + 32'(i * 4), 32'h0, 0, $urandom);
            gseq[i]  = if_gnt;
            wait_all = wait_all & cpu_wait;
        end
        chk("starve_grant_seq", 32'(gseq), 32'h0000_0008);
        chk("starve_wait",      32'(wait_all), 32'h1);
        step(1, 32'h300, 0, 4'h0, 32'h0, 32'h0, 0, $urandom);

        // Back-to-back routing
        step(1, 32'h500, 0, 4'h0, 32'h0, 32'h0, 0, 32'h11);
        step(0, 32'h0, 1, 4'h0, 32'h600, 32'h0, 0, 32'h22);
        chk("b2b_if_rdata", if_rdata, 32'h11);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        chk("b2b_d_rdata", d_rdata, 32'h22);

        // Reset in the cycle after a data read grant drops the response
        step(0, 32'h0, 1, 4'h0, 32'h700, 32'h0, 0, 32'h33);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h44);
        chk("rst_mid_d_rvalid", 32'(d_rvalid), 32'h0);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h55);
        step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h66);
        chk("rst_owner_none", 32'(dut.r_resp_owner), 32'h0);

        // Random traffic honouring the hold-until-grant contract
        p_if = 1'b0; p_d = 1'b0; lat = 0; max_lat = 0;
        r_ifa = 32'h0; r_da = 32'h0; r_dwd = 32'h0; r_dwe = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (!p_if) begin
                p_if  = ($urandom_range(0, 3) != 0);
                r_ifa = $urandom;
                lat   = 0;
            end
            if (!p_d) begin
                p_d   = ($urandom_range(0, 4) != 0);
                r_da  = $urandom;
                r_dwd = $urandom;
                r_dwe = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            end
            step(p_if, r_ifa, p_d, r_dwe, r_da, r_dwd, 0, $urandom);
            if (p_if) lat++;
            if (if_gnt) begin
                if (lat > max_lat) max_lat = lat;
                p_if = 1'b0;
            end
            if (d_gnt) p_d = 1'b0;
        end
        chk("fetch_worst_latency_ok", 32'(max_lat <= int'(SM) + 1), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data SRAM between the core's fetch port and its load/store port. The block grants at most one access per cycle and gives data priority over fetch. A bounded anti-starvation counter guarantees fetch progress. It raises `cpu_wait` to stall the pipeline while any request is waiting, and routes each read response back to the port that issued it. It sits between the core's `instr_addr`/`data_addr` ports and the memory macro.

## Interface
- `STARVE_MAX`, default 3: consecutive cycles fetch may lose to data before fetch is forced to win (1..15).
- `clk` in 1: core clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request. Held with `if_addr` stable until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch access accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid. Asserted the cycle after `if_gnt`.
- `if_rdata` out 32: instruction word.
- `d_req` in 1: data request. Held stable with its qualifiers until `d_gnt`.
- `d_we` in 4: byte write strobes. 0 means read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: write data, byte lanes pre-aligned by the LSU.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: data response (read data or write ack). Asserted the cycle after `d_gnt`.
- `d_rdata` out 32: read word. Zero for write acks.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 4: memory byte write enables.
- `mem_addr` out 32: word-aligned address, bits [1:0] forced to 0.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after a read `mem_en`.
- `cpu_wait` out 1: pipeline stall request.

## Operation
- **State:**
  - `starve_cnt`: 4 bits.
  - `resp_owner`: 2 bits, encoded NONE=00, IF=01, D=10.
  - `resp_is_wr`: 1 bit.
- **Arbitration (combinational, every cycle):**
  - Only `d_req`: grant D.
  - Only `if_req`: grant IF.
  - Both, and `starve_cnt < STARVE_MAX`: grant D.
  - Both, and `starve_cnt == STARVE_MAX`: grant IF.
  - Neither: no grant.
- **Memory drive:**
  - `mem_en = if_gnt | d_gnt`.
  - `mem_addr` and `mem_wdata` come from the granted port; `mem_we = d_gnt ? d_we : 0`.
  - When there is no grant, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- **starve_cnt:**
  - Increments (saturating at `STARVE_MAX`) when `if_req & d_gnt`.
  - Clears when `if_gnt` or `!if_req`.
- **Response tracking:**
  - On a grant, `resp_owner` is set to the granted port; otherwise it is set to NONE.
  - `resp_is_wr` is set to `d_gnt & (d_we != 0)`.
- **Response routing:**
  - `if_rvalid = (resp_owner == IF)`.
  - `d_rvalid = (resp_owner == D)`.
  - `if_rdata = if_rvalid ? mem_rdata : 0`.
  - `d_rdata = (d_rvalid & !resp_is_wr) ? mem_rdata : 0`.
- **Stall:** `cpu_wait = (if_req & !if_gnt) | (d_req & !d_gnt)`.
- **Requester contract:** a request is not withdrawn before its grant. Behaviour on withdrawal is unspecified, except that no memory write is issued without `d_gnt`.

## Timing
- Grant and the `mem_*` outputs are combinational from the requests and `starve_cnt` in cycle N.
- `rvalid` and `rdata` appear in cycle N+1.
- Throughput is one access per cycle. A new grant in cycle N+1 is legal alongside the response from cycle N.
- Writes are performed at the cycle-N edge. `d_rvalid` at N+1 is an acknowledgement only.
- **While `rst` is high:**
  - All outputs are forced to 0: grants, `mem_en`, `mem_we`, `cpu_wait`, both `rvalid`s and both `rdata`s.
  - At the edge, `starve_cnt` ← 0, `resp_owner` ← NONE and `resp_is_wr` ← 0.
- **Reset mid-operation:** a response due in the cycle after reset asserts is dropped. No `rvalid` is asserted for it.
- **Simultaneous requests with `STARVE_MAX` reached:**
  - Exactly one grant (IF).
  - `cpu_wait` = 1, because data is waiting.
  - The counter clears.
- **Worst-case fetch latency:** `STARVE_MAX` + 1 cycles from `if_req` to `if_gnt` under continuous data traffic.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `if_req=d_req=1`.
  - All outputs are 0 during reset.
  - First post-reset cycle with `STARVE_MAX=3`: `d_gnt=1`, `cpu_wait=1`.
- **Fetch alone:** `if_req=1`, `if_addr=0x0000_0106`, `mem_rdata=0x0013_0513` next cycle.
  - Same cycle: `mem_addr=0x0000_0104`, `mem_en=1`, `mem_we=0`.
  - Next cycle: `if_rvalid=1`, `if_rdata=0x0013_0513`, `d_rvalid=0`.
- **Data write:** `d_req=1`, `d_we=4'b1100`, `d_wdata=0xBEEF_0000`, `d_addr=0x200`.
  - Same cycle: `mem_we=4'b1100`, `mem_wdata=0xBEEF_0000`.
  - Next cycle: `d_rvalid=1`, `d_rdata=0`.
- **Starvation:** `if_req` held high; `d_req` high for 6 consecutive cycles, re-requested after every grant, with `STARVE_MAX=3`.
  - Grants go D, D, D, IF, D, D.
  - `starve_cnt` sequence: 1, 2, 3, 0, 1, 2.
  - `cpu_wait` stays 1 throughout.
- **Back-to-back routing:** IF read granted in cycle N, then D read in N+1 with `mem_rdata` = 0x11 and then 0x22.
  - `if_rdata=0x11` at N+1.
  - `d_rdata=0x22` at N+2.
  - No cross-port `rvalid`.
- **Reset mid-operation:** assert `rst` in the cycle after a D read grant.
  - `d_rvalid=0` in that cycle and all following reset cycles.
  - `resp_owner=NONE` after the edge.
